// File: rtl/mult16_pkg.sv
// mult16_pkg -- shared definitions for the multiplier final-adder pipeline.
//
// Holds the default product / half widths and the packed layout of the
// stage-1 pipeline register (low-half result plus the untouched upper
// halves of both compressor rows).
//
// The stage-1 struct is sized from the defaults below; a build that
// overrides DATA_W/HALF_W on the top must change these defaults as well.
package mult16_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int HALF_W_DEF = DATA_W_DEF / 2;
    localparam int HI_W_DEF   = DATA_W_DEF - HALF_W_DEF;

    // Stage-1 register contents: low-half sum and its carry-out, plus the
    // upper halves of the sum and carry rows waiting for stage 2.
    typedef struct packed {
        logic [HALF_W_DEF-1:0] lo_sum;
        logic                  lo_c;
        logic [HI_W_DEF-1:0]   sum_hi;
        logic [HI_W_DEF-1:0]   carry_hi;
    } s1_t;

endpackage

// File: rtl/mult16_half_add.sv
// mult16_half_add -- W-bit unsigned adder with carry in and carry out.
//
// Ports:
//   a, b  : W-bit operands
//   cin   : carry into bit 0
//   sum   : W-bit result
//   cout  : carry out of bit W-1
//
// Written as a plain '+' so synthesis maps it onto the dedicated carry chain.
module mult16_half_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mult16_cpa_pipe.sv
// mult16_cpa_pipe -- two-stage pipelined carry-propagate adder that turns
// the sum/carry rows of a multiplier compressor tree into the final product.
//
// Stage 1 adds the low halves and registers the low result, its carry and
// the upper halves of both rows. Stage 2 adds the upper halves plus the
// low carry and registers the full product. Valid/ready handshakes on both
// sides; one transaction per cycle while the consumer keeps out_ready high.
//
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : input handshake for in_sum / in_carry
//   in_sum, in_carry     : DATA_W-bit compressor rows (carry row pre-aligned)
//   out_valid / out_ready: output handshake for out_prod / out_cout
//   out_prod             : (in_sum + in_carry) mod 2^DATA_W
//   out_cout             : carry out of bit DATA_W-1 (diagnostic)
//   perf_cnt             : 32-bit output-transfer counter, only present when
//                          MULT16_CPA_PERF_CNT_EN is defined
module mult16_cpa_pipe
    import mult16_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int HALF_W = DATA_W / 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic [DATA_W-1:0] in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_prod,
    output logic              out_cout
`ifdef MULT16_CPA_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cnt
`endif
);

    localparam int HI_W = DATA_W - HALF_W;

    logic              s1_valid_reg, s1_valid_next;
    logic              s2_valid_reg, s2_valid_next;
    s1_t               s1_data_reg, s1_data_next;
    logic [DATA_W-1:0] out_prod_reg;
    logic              out_cout_reg;

    logic              s1_load;
    logic              s2_load;

    logic [HALF_W-1:0] lo_sum;
    logic              lo_c;
    logic [HI_W-1:0]   hi_sum;
    logic              hi_c;

    // ---------------- stage 1: low-half add ----------------
    mult16_half_add #(.W(HALF_W)) u_add_lo (
        .a    (in_sum[HALF_W-1:0]),
        .b    (in_carry[HALF_W-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_c)
    );

    always_comb begin
        s1_data_next          = s1_data_reg;
        s1_data_next.lo_sum   = lo_sum;
        s1_data_next.lo_c     = lo_c;
        s1_data_next.sum_hi   = in_sum[DATA_W-1:HALF_W];
        s1_data_next.carry_hi = in_carry[DATA_W-1:HALF_W];
    end

    // ---------------- stage 2: high-half add ----------------
    mult16_half_add #(.W(HI_W)) u_add_hi (
        .a    (s1_data_reg.sum_hi),
        .b    (s1_data_reg.carry_hi),
        .cin  (s1_data_reg.lo_c),
        .sum  (hi_sum),
        .cout (hi_c)
    );

    // ---------------- handshake control ----------------
    // Stage 1 can take a new word whenever it is empty, or when its current
    // word is guaranteed to move into stage 2 this same cycle.
    assign in_ready = !s1_valid_reg | !s2_valid_reg | out_ready;
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid_reg & (!s2_valid_reg | out_ready);

    always_comb begin
        s1_valid_next = s1_load | (s1_valid_reg & !s2_load);
        s2_valid_next = s2_load | (s2_valid_reg & !out_ready);
    end

    // Valid flags and the visible outputs are reset; the stage-1 payload
    // is qualified by s1_valid_reg and needs none.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            out_prod_reg <= '0;
            out_cout_reg <= 1'b0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            s2_valid_reg <= s2_valid_next;
            if (s2_load) begin
                out_prod_reg <= {hi_sum, s1_data_reg.lo_sum};
                out_cout_reg <= hi_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_data_reg <= s1_data_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_prod  = out_prod_reg;
    assign out_cout  = out_cout_reg;

`ifdef MULT16_CPA_PERF_CNT_EN
    // Counts accepted products; wraps naturally at 2^32.
    logic [31:0] perf_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_reg <= '0;
        end else if (s2_valid_reg && out_ready) begin
            perf_cnt_reg <= perf_cnt_reg + 32'd1;
        end
    end

    assign perf_cnt = perf_cnt_reg;
`endif

endmodule
